// File: rtl/cpu_state_dump.sv
// Debug sequencer: streams a snapshot of the register file, a window of data RAM,
// then HI and LO as tagged records on a valid/ready interface.
`timescale 1ns/1ps
module cpu_state_dump #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] HI_data,
  input  logic [31:0] LO_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_tag,
  output logic [7:0]  out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, RF_RD, RF_OUT, MEM_ADDR, MEM_WAIT, MEM_OUT, HI_OUT, LO_OUT
  } state_t;

  localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);

  state_t     state;
  logic [7:0] idx;
  logic [7:0] idx_inc;

  assign idx_inc = idx + 8'd1;

  // rf_addr and mem_addr are updated on entry to the read states so the
  // combinational regfile and the one-cycle RAM see a stable address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 8'd0;
      rf_addr   <= 5'd0;
      mem_addr  <= MEM_BASE;
      out_valid <= 1'b0;
      out_tag   <= 2'd0;
      out_index <= 8'd0;
      out_data  <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= 8'd0;
            rf_addr <= 5'd0;
            busy    <= 1'b1;
            state   <= RF_RD;
          end
        end
        RF_RD: begin
          out_data  <= rf_data;
          out_tag   <= 2'd0;
          out_index <= idx;
          out_valid <= 1'b1;
          state     <= RF_OUT;
        end
        RF_OUT: begin
          if (out_ready) begin
            if (idx == 8'd31) begin
              idx <= 8'd0;
              if (MEM_WORDS == 0) begin
                out_data  <= HI_data;
                out_tag   <= 2'd2;
                out_index <= 8'd0;
                state     <= HI_OUT;
              end else begin
                out_valid <= 1'b0;
                mem_addr  <= MEM_BASE;
                state     <= MEM_ADDR;
              end
            end else begin
              out_valid <= 1'b0;
              idx       <= idx_inc;
              rf_addr   <= idx_inc[4:0];
              state     <= RF_RD;
            end
          end
        end
        MEM_ADDR: state <= MEM_WAIT;
        MEM_WAIT: begin
          out_data  <= mem_data;
          out_tag   <= 2'd1;
          out_index <= idx;
          out_valid <= 1'b1;
          state     <= MEM_OUT;
        end
        MEM_OUT: begin
          if (out_ready) begin
            if (idx == LAST_MEM) begin
              out_data  <= HI_data;
              out_tag   <= 2'd2;
              out_index <= 8'd0;
              state     <= HI_OUT;
            end else begin
              out_valid <= 1'b0;
              idx       <= idx_inc;
              mem_addr  <= MEM_BASE + {22'd0, idx_inc, 2'b00};
              state     <= MEM_ADDR;
            end
          end
        end
        HI_OUT: begin
          if (out_ready) begin
            out_data  <= LO_data;
            out_tag   <= 2'd3;
            out_index <= 8'd0;
            state     <= LO_OUT;
          end
        end
        LO_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_state_dump.sv
// Scoreboard bench for cpu_state_dump: three instances (normal window, empty window,
// wrapping window) share stimulus; a per-instance monitor pops expected records.
`timescale 1ns/1ps
module tb_cpu_state_dump;

  typedef struct packed {
    logic [1:0]  tag;
    logic [7:0]  index;
    logic [31:0] data;
  } rec_t;

  localparam int N = 3;
  localparam logic [31:0] MB [N] = '{32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFF8};
  localparam int          MW [N] = '{16, 0, 4};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b0;
  logic [N-1:0] start = '0;
  logic [31:0] rf_off, mem_off, hi, lo;

  logic [4:0]   rf_addr   [N];
  logic [31:0]  rf_data   [N];
  logic [31:0]  mem_addr  [N];
  logic [31:0]  mem_data  [N];
  logic [31:0]  out_data  [N];
  logic [1:0]   out_tag   [N];
  logic [7:0]   out_index [N];
  logic [N-1:0] out_valid, busy, done;

  rec_t exp_q [N][$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: 32 registers, then the RAM window, then HI and LO.
  task automatic push_dump(input int k);
    logic [31:0] a;
    for (int r = 0; r < 32; r++) exp_q[k].push_back({2'd0, 8'(r), rf_off + 32'(r)});
    for (int i = 0; i < MW[k]; i++) begin
      a = MB[k] + 32'(4 * i);
      exp_q[k].push_back({2'd1, 8'(i), mem_off + {2'b00, a[31:2]}});
    end
    exp_q[k].push_back({2'd2, 8'd0, hi});
    exp_q[k].push_back({2'd3, 8'd0, lo});
  endtask

  for (genvar k = 0; k < N; k++) begin : g_dut
    assign rf_data[k] = rf_off + 32'(rf_addr[k]);
    always @(posedge clk) mem_data[k] <= mem_off + {2'b00, mem_addr[k][31:2]};

    cpu_state_dump #(.MEM_BASE(MB[k]), .MEM_WORDS(MW[k])) dut (
      .clk(clk), .reset(reset), .start(start[k]),
      .rf_addr(rf_addr[k]), .rf_data(rf_data[k]),
      .mem_addr(mem_addr[k]), .mem_data(mem_data[k]),
      .HI_data(hi), .LO_data(lo),
      .out_valid(out_valid[k]), .out_ready(out_ready),
      .out_tag(out_tag[k]), .out_index(out_index[k]), .out_data(out_data[k]),
      .busy(busy[k]), .done(done[k])
    );

    rec_t got, want, prev_rec;
    bit prev_stall = 1'b0;
    bit pend_done = 1'b0;
    logic [31:0] off;

    always @(negedge clk) begin
      if (reset) begin
        prev_stall = 1'b0;
        pend_done  = 1'b0;
      end else begin
        got = {out_tag[k], out_index[k], out_data[k]};
        if (prev_stall)
          chk(out_valid[k] && got == prev_rec, "stall_hold", 64'({out_valid[k], got}), 64'({1'b1, prev_rec}));
        chk(done[k] == pend_done, "done_pulse", 64'(done[k]), 64'(pend_done));
        pend_done = 1'b0;
        off = mem_addr[k] - MB[k];
        chk(off[1:0] == 2'b00 && off[31:2] < 30'(MW[k] == 0 ? 1 : MW[k]), "mem_addr_range",
            64'(mem_addr[k]), 64'(MB[k]));
        if (out_valid[k] && out_ready) begin
          if (exp_q[k].size() == 0) chk(1'b0, "extra_record", 64'(got), 64'(0));
          else begin
            want = exp_q[k].pop_front();
            chk(got == want, "record", 64'(got), 64'(want));
            pend_done = (want.tag == 2'd3);
          end
        end
        prev_stall = out_valid[k] && !out_ready;
        prev_rec   = got;
      end
    end
  end

  task automatic check_reset();
    for (int k = 0; k < N; k++) begin
      chk({out_valid[k], busy[k], done[k], out_tag[k], out_index[k], out_data[k], rf_addr[k]} == '0,
          "reset_outputs",
          64'({out_valid[k], busy[k], done[k], out_tag[k], out_index[k], out_data[k], rf_addr[k]}), 64'(0));
      chk(mem_addr[k] == MB[k], "reset_mem_addr", 64'(mem_addr[k]), 64'(MB[k]));
    end
  endtask

  task automatic do_start();
    for (int k = 0; k < N; k++) push_dump(k);
    start = '1;
    @(posedge clk); #1;
    start = '0;
  endtask

  task automatic randomize_data();
    rf_off  = $urandom;
    mem_off = $urandom;
    hi      = $urandom;
    lo      = $urandom;
  endtask

  // poke re-asserts start during register 5 and on the final LO handshake
  task automatic run_dump(input bit rnd, input bit poke);
    int n = 0;
    while (busy != '0 && n < 5000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke)
        for (int k = 0; k < N; k++)
          start[k] = out_valid[k] && ((out_tag[k] == 2'd0 && out_index[k] == 8'd5) || out_tag[k] == 2'd3);
      @(posedge clk); #1;
      n++;
    end
    start = '0;
    chk(busy == '0, "dump_timeout", 64'(busy), 64'(0));
  endtask

  initial begin
    int cyc;
    int n;
    int dcyc [N];
    rf_off  = 32'h0000_0100;
    mem_off = 32'hA000_0000;
    hi      = 32'h1111_1111;
    lo      = 32'h2222_2222;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset();

    // directed dump with timing
    out_ready = 1'b1;
    do_start();
    chk(busy == '1, "busy_cycle1", 64'(busy), 64'(3'b111));
    for (int k = 0; k < N; k++) dcyc[k] = -1;
    cyc = 1;
    while (cyc < 300 && (dcyc[0] < 0 || dcyc[1] < 0 || dcyc[2] < 0)) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < N; k++) if (done[k] && dcyc[k] < 0) dcyc[k] = cyc;
    end
    for (int k = 0; k < N; k++)
      chk(dcyc[k] == 64 + 3 * MW[k] + 3, "done_cycle", 64'(dcyc[k]), 64'(64 + 3 * MW[k] + 3));
    repeat (2) @(posedge clk); #1;

    // random backpressure
    for (int d = 0; d < 3; d++) begin
      randomize_data();
      do_start();
      run_dump(1'b1, 1'b0);
      @(posedge clk); #1;
    end

    // start during register 5 and with the final LO handshake
    randomize_data();
    out_ready = 1'b1;
    do_start();
    run_dump(1'b0, 1'b1);
    repeat (10) @(posedge clk); #1;
    chk(busy == '0, "ignored_start_idle", 64'(busy), 64'(0));
    for (int k = 0; k < N; k++) chk(exp_q[k].size() == 0, "ignored_start_queue", 64'(exp_q[k].size()), 64'(0));

    // reset during memory record 3
    randomize_data();
    out_ready = 1'b1;
    do_start();
    n = 0;
    while (!(out_valid[0] && out_tag[0] == 2'd1 && out_index[0] == 8'd3) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 500, "reach_mem3", 64'(n), 64'(500));
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset();
    reset = 1'b0;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    repeat (3) @(posedge clk); #1;
    chk(done == '0 && busy == '0, "post_reset_quiet", 64'({done, busy}), 64'(0));

    randomize_data();
    do_start();
    run_dump(1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < N; k++) chk(exp_q[k].size() == 0, "final_queue", 64'(exp_q[k].size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
